// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module   : control_unit
// Purpose  : Hardwired T0-T7 sequencer for the single-bus datapath, with
//            pause (stop) and halt. Define CU_MULDIV_EN to enable mul/div.
// Revision : 1.0 - initial release
// ============================================================================
module control_unit #(
    parameter int OPW = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ir,
    input  logic        con_ff,
    input  logic        stop,
    output logic        gra,
    output logic        grb,
    output logic        grc,
    output logic        r_in,
    output logic        r_out,
    output logic        ba_out,
    output logic        pc_in,
    output logic        pc_out,
    output logic        inc_pc,
    output logic        ir_in,
    output logic        y_in,
    output logic        z_in,
    output logic        z_low_out,
    output logic        z_high_out,
    output logic        hi_in,
    output logic        hi_out,
    output logic        lo_in,
    output logic        lo_out,
    output logic        c_out,
    output logic        mar_in,
    output logic        mdr_in,
    output logic        mdr_out,
    output logic        read,
    output logic        write,
    output logic        inport_out,
    output logic        outport_in,
    output logic        con_in,
    output logic [3:0]  alu_op,
    output logic        run
);

    localparam logic [3:0] c_ST_RST   = 4'd0;
    localparam logic [3:0] c_ST_T0    = 4'd1;
    localparam logic [3:0] c_ST_T1    = 4'd2;
    localparam logic [3:0] c_ST_T2    = 4'd3;
    localparam logic [3:0] c_ST_T3    = 4'd4;
    localparam logic [3:0] c_ST_T4    = 4'd5;
    localparam logic [3:0] c_ST_T5    = 4'd6;
    localparam logic [3:0] c_ST_T6    = 4'd7;
    localparam logic [3:0] c_ST_T7    = 4'd8;
    localparam logic [3:0] c_ST_PAUSE = 4'd9;
    localparam logic [3:0] c_ST_HALT  = 4'd10;

    localparam logic [OPW-1:0] c_OP_LD   = OPW'(0);
    localparam logic [OPW-1:0] c_OP_LDI  = OPW'(1);
    localparam logic [OPW-1:0] c_OP_ST   = OPW'(2);
    localparam logic [OPW-1:0] c_OP_ADD  = OPW'(3);
    localparam logic [OPW-1:0] c_OP_SUB  = OPW'(4);
    localparam logic [OPW-1:0] c_OP_SHR  = OPW'(5);
    localparam logic [OPW-1:0] c_OP_SHL  = OPW'(6);
    localparam logic [OPW-1:0] c_OP_ROR  = OPW'(7);
    localparam logic [OPW-1:0] c_OP_ROL  = OPW'(8);
    localparam logic [OPW-1:0] c_OP_AND  = OPW'(9);
    localparam logic [OPW-1:0] c_OP_OR   = OPW'(10);
    localparam logic [OPW-1:0] c_OP_ADDI = OPW'(11);
    localparam logic [OPW-1:0] c_OP_ANDI = OPW'(12);
    localparam logic [OPW-1:0] c_OP_ORI  = OPW'(13);
`ifdef CU_MULDIV_EN
    localparam logic [OPW-1:0] c_OP_MUL  = OPW'(14);
    localparam logic [OPW-1:0] c_OP_DIV  = OPW'(15);
`endif
    localparam logic [OPW-1:0] c_OP_NEG  = OPW'(16);
    localparam logic [OPW-1:0] c_OP_NOT  = OPW'(17);
    localparam logic [OPW-1:0] c_OP_BR   = OPW'(18);
    localparam logic [OPW-1:0] c_OP_JR   = OPW'(19);
    localparam logic [OPW-1:0] c_OP_IN   = OPW'(21);
    localparam logic [OPW-1:0] c_OP_OUT  = OPW'(22);
    localparam logic [OPW-1:0] c_OP_MFHI = OPW'(23);
    localparam logic [OPW-1:0] c_OP_MFLO = OPW'(24);
    localparam logic [OPW-1:0] c_OP_HALT = OPW'(26);

    logic [3:0]     r_state;
    logic [3:0]     w_next;
    logic [3:0]     w_last;
    logic [3:0]     w_alu_code;
    logic [OPW-1:0] w_op;
    logic           w_is_alu;
    logic           w_is_imm;
    logic           w_is_unary;
    logic           w_is_addr;
    logic           w_is_muldiv;
    logic           w_unused;

    assign w_op       = ir[31 -: OPW];
    assign w_unused   = ^ir[31-OPW:0];
    assign w_is_alu   = (w_op >= c_OP_ADD) && (w_op <= c_OP_OR);
    assign w_is_imm   = (w_op >= c_OP_ADDI) && (w_op <= c_OP_ORI);
    assign w_is_unary = (w_op == c_OP_NEG) || (w_op == c_OP_NOT);
    assign w_is_addr  = (w_op == c_OP_LD) || (w_op == c_OP_LDI) || (w_op == c_OP_ST);
`ifdef CU_MULDIV_EN
    assign w_is_muldiv = (w_op == c_OP_MUL) || (w_op == c_OP_DIV);
`else
    assign w_is_muldiv = 1'b0;
`endif

    always_comb begin
        w_alu_code = 4'h0;
        case (w_op)
            c_OP_ADD, c_OP_ADDI: w_alu_code = 4'h2;
            c_OP_SUB:            w_alu_code = 4'h3;
            c_OP_SHR:            w_alu_code = 4'h4;
            c_OP_SHL:            w_alu_code = 4'h5;
            c_OP_ROR:            w_alu_code = 4'h6;
            c_OP_ROL:            w_alu_code = 4'h7;
            c_OP_OR, c_OP_ORI:   w_alu_code = 4'h1;
`ifdef CU_MULDIV_EN
            c_OP_MUL:            w_alu_code = 4'h8;
            c_OP_DIV:            w_alu_code = 4'h9;
`endif
            c_OP_NEG:            w_alu_code = 4'hA;
            c_OP_NOT:            w_alu_code = 4'hB;
            default:             w_alu_code = 4'h0;
        endcase
    end

    // Final step per opcode; anything without an execute phase ends at T2.
    always_comb begin
        w_last = c_ST_T2;
        if (w_is_alu || w_is_imm || (w_op == c_OP_LDI))
            w_last = c_ST_T5;
        else if (w_is_unary)
            w_last = c_ST_T4;
        else if ((w_op == c_OP_LD) || (w_op == c_OP_ST))
            w_last = c_ST_T7;
        else if ((w_op == c_OP_BR) || w_is_muldiv)
            w_last = c_ST_T6;
        else if ((w_op == c_OP_JR) || (w_op == c_OP_IN) || (w_op == c_OP_OUT) ||
                 (w_op == c_OP_MFHI) || (w_op == c_OP_MFLO))
            w_last = c_ST_T3;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_RST:   w_next = c_ST_T0;
            c_ST_PAUSE: w_next = stop ? c_ST_PAUSE : c_ST_T0;
            c_ST_HALT:  w_next = c_ST_HALT;
            default: begin
                if (r_state > c_ST_T7)
                    w_next = c_ST_RST;
                else if (r_state == w_last) begin
                    if (w_op == c_OP_HALT)
                        w_next = c_ST_HALT;
                    else
                        w_next = stop ? c_ST_PAUSE : c_ST_T0;
                end else
                    w_next = r_state + 4'd1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= c_ST_RST;
        else
            r_state <= w_next;
    end

    always_comb begin
        gra = 1'b0;  grb = 1'b0;  grc = 1'b0;  r_in = 1'b0;  r_out = 1'b0;
        ba_out = 1'b0;  pc_in = 1'b0;  pc_out = 1'b0;  inc_pc = 1'b0;
        ir_in = 1'b0;  y_in = 1'b0;  z_in = 1'b0;  z_low_out = 1'b0;
        z_high_out = 1'b0;  hi_in = 1'b0;  hi_out = 1'b0;  lo_in = 1'b0;
        lo_out = 1'b0;  c_out = 1'b0;  mar_in = 1'b0;  mdr_in = 1'b0;
        mdr_out = 1'b0;  read = 1'b0;  write = 1'b0;  inport_out = 1'b0;
        outport_in = 1'b0;  con_in = 1'b0;  alu_op = 4'h0;
        run = (r_state != c_ST_HALT);
        case (r_state)
            c_ST_T0: begin
                pc_out = 1'b1;  mar_in = 1'b1;  inc_pc = 1'b1;  z_in = 1'b1;  alu_op = 4'h2;
            end
            c_ST_T1: begin
                z_low_out = 1'b1;  pc_in = 1'b1;  read = 1'b1;  mdr_in = 1'b1;
            end
            c_ST_T2: begin
                mdr_out = 1'b1;  ir_in = 1'b1;
            end
            c_ST_T3: begin
                if (w_is_alu || w_is_imm) begin
                    grb = 1'b1;  r_out = 1'b1;  y_in = 1'b1;
                end else if (w_is_unary) begin
                    grb = 1'b1;  r_out = 1'b1;  z_in = 1'b1;  alu_op = w_alu_code;
                end else if (w_is_addr) begin
                    grb = 1'b1;  ba_out = 1'b1;  y_in = 1'b1;
                end else if (w_is_muldiv) begin
                    gra = 1'b1;  r_out = 1'b1;  y_in = 1'b1;
                end else if (w_op == c_OP_BR) begin
                    gra = 1'b1;  r_out = 1'b1;  con_in = 1'b1;
                end else if (w_op == c_OP_JR) begin
                    gra = 1'b1;  r_out = 1'b1;  pc_in = 1'b1;
                end else if (w_op == c_OP_IN) begin
                    inport_out = 1'b1;  gra = 1'b1;  r_in = 1'b1;
                end else if (w_op == c_OP_OUT) begin
                    gra = 1'b1;  r_out = 1'b1;  outport_in = 1'b1;
                end else if (w_op == c_OP_MFHI) begin
                    hi_out = 1'b1;  gra = 1'b1;  r_in = 1'b1;
                end else if (w_op == c_OP_MFLO) begin
                    lo_out = 1'b1;  gra = 1'b1;  r_in = 1'b1;
                end
            end
            c_ST_T4: begin
                if (w_is_alu) begin
                    grc = 1'b1;  r_out = 1'b1;  z_in = 1'b1;  alu_op = w_alu_code;
                end else if (w_is_imm) begin
                    c_out = 1'b1;  z_in = 1'b1;  alu_op = w_alu_code;
                end else if (w_is_unary) begin
                    z_low_out = 1'b1;  gra = 1'b1;  r_in = 1'b1;
                end else if (w_is_addr) begin
                    c_out = 1'b1;  z_in = 1'b1;  alu_op = 4'h2;
                end else if (w_is_muldiv) begin
                    grb = 1'b1;  r_out = 1'b1;  z_in = 1'b1;  alu_op = w_alu_code;
                end else if (w_op == c_OP_BR) begin
                    pc_out = 1'b1;  y_in = 1'b1;
                end
            end
            c_ST_T5: begin
                if (w_is_alu || w_is_imm || (w_op == c_OP_LDI)) begin
                    z_low_out = 1'b1;  gra = 1'b1;  r_in = 1'b1;
                end else if (w_is_addr) begin
                    z_low_out = 1'b1;  mar_in = 1'b1;
                end else if (w_is_muldiv) begin
                    z_low_out = 1'b1;  lo_in = 1'b1;
                end else if (w_op == c_OP_BR) begin
                    c_out = 1'b1;  z_in = 1'b1;  alu_op = 4'h2;
                end
            end
            c_ST_T6: begin
                if (w_op == c_OP_LD) begin
                    read = 1'b1;  mdr_in = 1'b1;
                end else if (w_op == c_OP_ST) begin
                    gra = 1'b1;  r_out = 1'b1;  mdr_in = 1'b1;
                end else if (w_is_muldiv) begin
                    z_high_out = 1'b1;  hi_in = 1'b1;
                end else if (w_op == c_OP_BR) begin
                    z_low_out = 1'b1;  pc_in = con_ff;
                end
            end
            c_ST_T7: begin
                if (w_op == c_OP_LD) begin
                    mdr_out = 1'b1;  gra = 1'b1;  r_in = 1'b1;
                end else if (w_op == c_OP_ST) begin
                    write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire
